// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the fetch stage and the memory stage.
// One latched transaction at a time; MEM has priority, bounded by a burst limit while a fetch waits.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRData,
    output logic        IAck,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic [31:0] DRData,
    output logic        DAck,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic        StallIF,
    output logic        StallMEM,
    output logic [1:0]  Grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_e;

    localparam logic [3:0] DCNT_MAX = 4'(MAX_D_BURST);

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        if (cnt < DCNT_MAX) begin
            sat_inc = cnt + 4'd1;
        end else begin
            sat_inc = DCNT_MAX;
        end
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        burst_ok_s;

    assign burst_ok_s = (dcnt_q < DCNT_MAX);

    // Arbitration decision, request latching and access completion
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (DReq && (!IReq || burst_ok_s)) begin
                    state_d = GRANT_D;
                    addr_d  = DAddr;
                    wdata_d = DWData;
                    we_d    = DWe;
                    if (IReq) begin
                        dcnt_d = sat_inc(dcnt_q);
                    end else begin
                        dcnt_d = 4'd0;
                    end
                end else if (IReq) begin
                    state_d = GRANT_I;
                    addr_d  = IAddr;
                    wdata_d = 32'h0000_0000;
                    we_d    = 1'b0;
                    dcnt_d  = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (MemReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dcnt_q  <= 4'd0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Memory side is driven only from the latched registers so it stays stable across wait states
    assign Grant    = state_q;
    assign MemReq   = (state_q != IDLE);
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign MemWe    = we_q;

    assign IAck     = (state_q == GRANT_I) && MemReady;
    assign DAck     = (state_q == GRANT_D) && MemReady;
    assign IRData   = MemRData;
    assign DRData   = MemRData;

    assign StallIF  = IReq && !IAck;
    assign StallMEM = DReq && !DAck;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory of the pipelined MIPS core between the fetch stage (IF) and the memory stage (MEM). It latches and sequences one memory transaction at a time with a variable-latency ready handshake. It returns read data and one-cycle acknowledges to the winning requester and produces per-stage stall requests that the hazard unit ORs into StallF/StallD/FlushE. MEM has priority; a burst limit prevents fetch starvation.

## Interface

- MAX_D_BURST, 4: consecutive data grants allowed while IReq is pending before IF is forced a grant (1..15).
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- IReq  in  1  fetch request, held until IAck
- IAddr  in  32  fetch word address
- IRData  out  32  fetch read data, valid when IAck=1
- IAck  out  1  fetch transaction complete (one-cycle pulse)
- DReq  in  1  data request, held until DAck
- DWe  in  1  1 = store, 0 = load
- DAddr  in  32  data address
- DWData  in  32  store data
- DRData  out  32  load data, valid when DAck=1
- DAck  out  1  data transaction complete (one-cycle pulse)
- MemReq  out  1  memory access strobe, held until MemReady
- MemWe  out  1  memory write enable
- MemAddr  out  32  memory address
- MemWData  out  32  memory write data
- MemRData  in  32  memory read data, valid with MemReady
- MemReady  in  1  memory completes current access this cycle
- StallIF  out  1  IReq & ~IAck
- StallMEM  out  1  DReq & ~DAck
- Grant  out  2  00 idle, 01 IF owns port, 10 MEM owns port

## Operation

- States: IDLE, GRANT_I, GRANT_D. Grant is the state encoding.
- IDLE, DReq=1 and (IReq=0 or dcnt<MAX_D_BURST): go to GRANT_D. Latch DAddr, DWData, DWe into the address/data/write-enable registers.
- IDLE, otherwise if IReq=1: go to GRANT_I. Latch IAddr; latched We=0.
- IDLE, no request: stay. MemReq=0.
- GRANT_x: MemReq=1, MemAddr/MemWData/MemWe come from the latched registers only. Requester input changes after the grant have no effect.
- GRANT_x with MemReady=1: the matching ack is 1 combinationally in the same cycle. The matching RData passes MemRData through; stores also ack, with DRData don't-care. Next state is IDLE.
- GRANT_x with MemReady=0: stay, with all Mem* outputs stable.
- IAck=0 outside GRANT_I; DAck=0 outside GRANT_D. MemReady in IDLE is ignored.
- dcnt (4 bit) updates at grant decision:
  - GRANT_D taken with IReq=1: increment, saturating at MAX_D_BURST.
  - GRANT_I taken, or IReq=0 at decision: clear to 0.
- Requester dropping its Req before ack is a protocol violation. The transaction still completes and the ack still pulses.
- StallIF/StallMEM are purely combinational from current inputs and acks.

## Timing

- Reset (rst_n=0 at an edge): state IDLE, dcnt=0, latched regs=0. All outputs are then 0: MemReq, MemWe, MemAddr, MemWData, IAck, DAck, Grant. IRData/DRData follow MemRData but are qualified by acks.
- Reset during GRANT_x abandons the access. MemReq drops the cycle after the reset edge, and the memory model must tolerate this.
- Latency: Req seen high at edge k gives a grant at k. MemReq is high in cycle k..k+1, and the ack comes in the first cycle with MemReady. The minimum access is 2 cycles (arbitration cycle plus one memory cycle).
- After an ack there is always one IDLE cycle. Back-to-back accesses sustain one access per 2 cycles with zero-wait memory.
- Simultaneous IReq and DReq in IDLE: D wins unless dcnt==MAX_D_BURST.

## Test plan

- Reset: hold rst_n=0 with IReq=DReq=1 -> all outputs 0, Grant=00. Release -> GRANT_D next edge, MemAddr=DAddr.
- Lone fetch, MemReady tied 1: IReq=1, IAddr=0x40, MemRData=0x8C010004 -> Grant=01 one cycle after request. IAck=1 with IRData=0x8C010004 in that cycle. StallIF=1 until ack.
- Wait states: DReq=1, DWe=1, DAddr=0x100, DWData=0xDEADBEEF, MemReady low for 3 cycles -> MemReq/MemWe/MemAddr/MemWData stable for 4 cycles. DAck pulses exactly once. DAddr changed mid-access is not propagated.
- Starvation limit, MAX_D_BURST=4: IReq and DReq held continuously, with DReq re-raised after each ack -> grant order D,D,D,D,I,D,D,D,D,I. dcnt returns to 0 after each I grant.
- Reset mid-access: GRANT_I with MemReady=0, assert rst_n=0 -> MemReq=0 and Grant=00 after the edge. No IAck is produced.
- Stray MemReady: MemReady=1 in IDLE with no requests -> IAck=DAck=0 and state stays IDLE.
